onehot_encode_fifo: RTL and testbench

- Downstream consumer of the 3-to-8 decoder stage.
- Each cycle it samples the decoder's 8-bit output and enable, checks the one-hot legality rules and encodes legal codes back to a 3-bit index.
- Legal indices are buffered in a small FIFO and drained through a valid/ready interface.
- Illegal decoder output (multi-hot, all-zero while enabled, any bit while disabled) is flagged and counted, never forwarded.

---
 rtl/onehot_encode_fifo.sv | 78 +++++++
 tb/tb_onehot_encode_fifo.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/onehot_encode_fifo.sv
// Checks decoder output for one-hot legality and encodes legal codes to an index.
// Legal indices are queued in a small FIFO; illegal codes raise a sticky flag and are counted.
module onehot_encode_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_en,
  input  logic [WIDTH-1:0] dec_out,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] count,
  output logic             err_illegal,
  input  logic             err_clr,
  output logic [7:0]       illegal_cnt,
  output logic [7:0]       drop_cnt
);

  logic [DEPTH-1:0][IDX_W-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic                        onehot, legal, illegal, push, pop;
  logic [IDX_W-1:0]            enc_idx;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign onehot  = (dec_out != '0) && ((dec_out & (dec_out - WIDTH'(1))) == '0);
  assign legal   = dec_en && onehot;
  assign illegal = (dec_en && !onehot) || (!dec_en && (dec_out != '0));

  always_comb begin
    enc_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (dec_out[i]) enc_idx = enc_idx | IDX_W'(i);
  end

  // Gated by rst_n so the decoder side sees no acceptance while held in reset.
  assign in_ready  = rst_n && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_idx   = mem[rd_ptr];
  assign push      = legal && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc_idx;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
      illegal_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (illegal)      err_illegal <= 1'b1;
      else if (err_clr) err_illegal <= 1'b0;
      if (illegal && illegal_cnt != 8'hFF)          illegal_cnt <= illegal_cnt + 8'd1;
      if (legal && !in_ready && drop_cnt != 8'hFF)  drop_cnt    <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_onehot_encode_fifo.sv
// Directed bench for onehot_encode_fifo with hand-computed expectations.
module tb_onehot_encode_fifo;
  logic       clk = 1'b0;
  logic       rst_n, dec_en, out_ready, err_clr;
  logic [7:0] dec_out;
  logic       in_ready, out_valid, err_illegal;
  logic [2:0] out_idx;
  logic [2:0] count;
  logic [7:0] illegal_cnt, drop_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int q[$];

  onehot_encode_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .dec_en(dec_en), .dec_out(dec_out),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .count(count), .err_illegal(err_illegal),
    .err_clr(err_clr), .illegal_cnt(illegal_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs, take one edge, settle just after it.
  task automatic cyc(input logic en, input logic [7:0] d, input logic rdy, input logic clr);
    dec_en = en; dec_out = d; out_ready = rdy; err_clr = clr;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; dec_en = 1'b0; dec_out = '0; out_ready = 1'b0; err_clr = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_inready", in_ready, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_icnt", illegal_cnt, 0);
    chk("rst_dcnt", drop_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rel_inready", in_ready, 1);

    // 1: fill four, then drain in order
    cyc(1, 8'h01, 0, 0);
    chk("t1_lat_valid", out_valid, 1);
    chk("t1_lat_idx", out_idx, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h04, 0, 0);
    cyc(1, 8'h08, 0, 0);
    chk("t1_full_count", count, 4);
    chk("t1_full_inready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pop_idx", out_idx, i);
      cyc(0, 8'h00, 1, 0);
    end
    chk("t1_empty_count", count, 0);
    chk("t1_empty_valid", out_valid, 0);
    chk("t1_err", err_illegal, 0);

    // 2: drops when full
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h04, 0, 0);
    cyc(1, 8'h08, 0, 0);
    repeat (3) cyc(1, 8'h80, 0, 0);
    chk("t2_drop", drop_cnt, 3);
    chk("t2_count", count, 4);
    chk("t2_head_hold", out_idx, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_pop_idx", out_idx, i);
      cyc(0, 8'h00, 1, 0);
    end
    chk("t2_count_end", count, 0);
    chk("t2_err", err_illegal, 0);

    // 3: three illegal flavours
    cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h00, 0, 0);
    cyc(0, 8'h40, 0, 0);
    chk("t3_icnt", illegal_cnt, 3);
    chk("t3_err", err_illegal, 1);
    chk("t3_count", count, 0);

    // 4: saturation and clear priority
    repeat (300) cyc(1, 8'h03, 0, 0);
    chk("t4_sat", illegal_cnt, 255);
    cyc(0, 8'h00, 0, 1);
    chk("t4_clr_err", err_illegal, 0);
    chk("t4_clr_icnt", illegal_cnt, 255);
    cyc(1, 8'h03, 0, 1);
    chk("t4_setwins", err_illegal, 1);
    chk("t4_icnt_hold", illegal_cnt, 255);
    chk("t4_dcnt", drop_cnt, 3);

    // 5: simultaneous push/pop and pointer wrap
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    chk("t5_count2", count, 2);
    cyc(1, 8'h20, 1, 0);
    chk("t5_pushpop_count", count, 2);
    chk("t5_head1", out_idx, 1);
    cyc(0, 8'h00, 1, 0);
    chk("t5_head5", out_idx, 5);
    chk("t5_count1", count, 1);
    q.push_back(5);
    for (int k = 0; k < 10; k++) begin
      chk("t5_wrap_idx", out_idx, q[0]);
      void'(q.pop_front());
      q.push_back(k % 8);
      cyc(1, 8'(1 << (k % 8)), 1, 0);
      chk("t5_wrap_count", count, 1);
    end
    chk("t5_final_idx", out_idx, q[0]);
    cyc(0, 8'h00, 1, 0);
    chk("t5_drained", count, 0);

    // 6: asynchronous reset mid-cycle
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h04, 0, 0);
    chk("t6_count3", count, 3);
    dec_en = 1'b0; dec_out = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ar_valid", out_valid, 0);
    chk("t6_ar_count", count, 0);
    chk("t6_ar_icnt", illegal_cnt, 0);
    chk("t6_ar_dcnt", drop_cnt, 0);
    chk("t6_ar_err", err_illegal, 0);
    chk("t6_ar_inready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    cyc(1, 8'h04, 0, 0);
    chk("t6_post_valid", out_valid, 1);
    chk("t6_post_idx", out_idx, 2);
    chk("t6_post_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
